main_fsm: RTL and testbench

- Multicycle control unit for the RV32I subset core, directly upstream of the ALU decoder.
- Sequences fetch / decode / execute / memory / writeback per instruction.
- Drives the 2-bit ALU-op class consumed by the ALU decoder.
- Consumes that decoder's branch-taken result to gate the PC update.
- Stalls on a simple request/ready memory handshake.

---
 rtl/core_pkg.sv | 63 ++++++
 rtl/main_fsm_outdec.sv | 80 ++++++++
 rtl/main_fsm.sv | 117 +++++++++++
 tb/tb_main_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes,
// ALU-op classes and datapath mux selects, plus the control-word layout.
package core_pkg;

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC_R = 4'd6;
    localparam logic [3:0] EXEC_I = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] JAL    = 4'd10;
    localparam logic [3:0] ERR    = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_I   = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef logic [3:0] state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // States that wait on the memory handshake and therefore run the stall counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational decode of the sequencer state into the datapath control word.
// Only the FETCH loads and the branch PC load depend on live inputs.
module main_fsm_outdec
    import core_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       branch,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALU;
            end
            DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_R;
            end
            EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_I;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = branch;
            end
            JAL: begin
                // Target was formed in DECODE; here oldPC+4 is computed for rd.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle instruction sequencer with memory-stall timeout. Control outputs
// are forced to zero while rst_n is low so no strobe leaks during reset.
module main_fsm
    import core_pkg::*;
#(
    parameter logic [7:0] STALL_MAX = 8'd255
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t     state_q, state_d;
    logic [7:0] stall_q, stall_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;
    logic       timeout;

    assign timeout = (stall_q == STALL_MAX) && !mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ready)    state_d = DECODE;
                else if (timeout) state_d = ERR;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_B:              state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = ERR;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_STORE) ? MEMWR : MEMRD;
            MEMRD: begin
                if (mem_ready)    state_d = MEMWB;
                else if (timeout) state_d = ERR;
            end
            MEMWB:   state_d = FETCH;
            MEMWR: begin
                if (mem_ready)    state_d = FETCH;
                else if (timeout) state_d = ERR;
            end
            EXEC_R:  state_d = ALUWB;
            EXEC_I:  state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JAL:     state_d = ALUWB;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Counter restarts on any state change so each access gets a fresh budget.
    always_comb begin
        stall_d = stall_q;
        if (state_d != state_q) begin
            stall_d = 8'd0;
        end else if (is_wait_state(state_q) && !mem_ready) begin
            stall_d = stall_q + 8'd1;
        end
    end

    assign illegal_d = illegal_q | (state_d == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            stall_q   <= 8'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            illegal_q <= illegal_d;
        end
    end

    main_fsm_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .branch    (branch),
        .ctrl      (ctrl)
    );

    assign mem_req    = rst_n & ctrl.mem_req;
    assign mem_write  = rst_n & ctrl.mem_write;
    assign adr_src    = rst_n & ctrl.adr_src;
    assign ir_write   = rst_n & ctrl.ir_write;
    assign pc_write   = rst_n & ctrl.pc_write;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign alu_src_a  = rst_n ? ctrl.alu_src_a  : 2'b00;
    assign alu_src_b  = rst_n ? ctrl.alu_src_b  : 2'b00;
    assign result_src = rst_n ? ctrl.result_src : 2'b00;
    assign alu_op     = rst_n ? ctrl.alu_op     : 2'b00;
    assign illegal    = rst_n & illegal_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Vector/scoreboard bench for main_fsm: per-cycle expected state and control
// word are queued when inputs are driven and compared on the falling edge.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [3:0] state_o;
    logic [14:0] act;

    always #5 clk = ~clk;

    main_fsm #(.STALL_MAX(8'd4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .branch     (branch),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,illegal,a,b,res,aluop}
    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
                  alu_src_a, alu_src_b, result_src, alu_op};

    localparam logic [14:0] C_F1   = 15'b1001100_00_10_10_00;
    localparam logic [14:0] C_F0   = 15'b1000000_00_10_10_00;
    localparam logic [14:0] C_DEC  = 15'b0000000_01_01_00_00;
    localparam logic [14:0] C_MA   = 15'b0000000_10_01_00_00;
    localparam logic [14:0] C_MR   = 15'b1010000_00_00_00_00;
    localparam logic [14:0] C_MWB  = 15'b0000010_00_00_01_00;
    localparam logic [14:0] C_MW   = 15'b1110000_00_00_00_00;
    localparam logic [14:0] C_EXR  = 15'b0000000_10_00_00_10;
    localparam logic [14:0] C_EXI  = 15'b0000000_10_01_00_01;
    localparam logic [14:0] C_AWB  = 15'b0000010_00_00_00_00;
    localparam logic [14:0] C_BRT  = 15'b0000100_10_00_00_00;
    localparam logic [14:0] C_BRN  = 15'b0000000_10_00_00_00;
    localparam logic [14:0] C_JAL  = 15'b0000100_01_10_00_00;
    localparam logic [14:0] C_ERR  = 15'b0000001_00_00_00_00;

    localparam logic [6:0] O_LW = 7'b0000011, O_SW = 7'b0100011, O_R = 7'b0110011;
    localparam logic [6:0] O_I = 7'b0010011, O_B = 7'b1100011, O_JAL = 7'b1101111;
    localparam logic [6:0] O_BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic        br;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] ctl;
        int          tag;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tagn   = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic br, input logic rdy,
                                input logic [3:0] st, input logic [14:0] ctl);
        vec_t v;
        v.op = op; v.br = br; v.rdy = rdy; v.st = st; v.ctl = ctl; v.tag = tagn;
        tagn++;
        return v;
    endfunction

    task automatic add(input logic [6:0] op, input logic br, input logic rdy,
                       input logic [3:0] st, input logic [14:0] ctl);
        vecs.push_back(mk(op, br, rdy, st, ctl));
    endtask

    // Called at posedge+1: drive this cycle's inputs, queue expectation, advance.
    task automatic step(input vec_t v);
        opcode    = v.op;
        branch    = v.br;
        mem_ready = v.rdy;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic stepv(input logic [6:0] op, input logic br, input logic rdy,
                         input logic [3:0] st, input logic [14:0] ctl);
        step(mk(op, br, rdy, st, ctl));
    endtask

    task automatic check_rst(input string name);
        checks++;
        if (state_o !== 4'd0 || act !== 15'd0) begin
            errors++;
            $display("FAIL %s: state=%0d ctl=%b, required state=0 ctl=%b", name, state_o, act, 15'd0);
        end else begin
            $display("reset %s: state=%0d ctl=%b", name, state_o, act);
        end
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        #1;
        check_rst(name);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            vec_t e;
            e = sb_q.pop_front();
            checks += 2;
            if (state_o !== e.st) begin
                errors++;
                $display("FAIL state vec%0d: got %0d, required %0d", e.tag, state_o, e.st);
            end
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctrl vec%0d: got %b, required %b", e.tag, act, e.ctl);
            end
            if (state_o === e.st && act === e.ctl)
                $display("vec%0d op=%b rdy=%b br=%b state=%0d ctl=%b", e.tag, e.op, e.rdy, e.br, state_o, act);
        end
    end

    initial begin
        rst_n = 1'b0; opcode = O_R; branch = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_rst("reset_hold");
        rst_n = 1'b1;

        // R-type, I-type, zero-wait
        add(O_R, 0, 1, 4'd0, C_F1);  add(O_R, 0, 1, 4'd1, C_DEC);
        add(O_R, 0, 1, 4'd6, C_EXR); add(O_R, 0, 1, 4'd8, C_AWB);
        add(O_I, 0, 1, 4'd0, C_F1);  add(O_I, 0, 1, 4'd1, C_DEC);
        add(O_I, 0, 1, 4'd7, C_EXI); add(O_I, 0, 1, 4'd8, C_AWB);
        // load with three wait states in MEMRD
        add(O_LW, 0, 1, 4'd0, C_F1); add(O_LW, 0, 1, 4'd1, C_DEC);
        add(O_LW, 0, 1, 4'd2, C_MA);
        add(O_LW, 0, 0, 4'd3, C_MR); add(O_LW, 0, 0, 4'd3, C_MR);
        add(O_LW, 0, 0, 4'd3, C_MR); add(O_LW, 0, 1, 4'd3, C_MR);
        add(O_LW, 0, 0, 4'd4, C_MWB);
        // store with one wait state
        add(O_SW, 0, 1, 4'd0, C_F1); add(O_SW, 0, 1, 4'd1, C_DEC);
        add(O_SW, 0, 1, 4'd2, C_MA); add(O_SW, 0, 0, 4'd5, C_MW);
        add(O_SW, 0, 1, 4'd5, C_MW);
        // branch taken / not taken
        add(O_B, 1, 1, 4'd0, C_F1);  add(O_B, 1, 1, 4'd1, C_DEC);
        add(O_B, 1, 1, 4'd9, C_BRT);
        add(O_B, 0, 1, 4'd0, C_F1);  add(O_B, 0, 0, 4'd1, C_DEC);
        add(O_B, 0, 0, 4'd9, C_BRN);
        // jal, mem_ready ignored outside memory states
        add(O_JAL, 0, 1, 4'd0, C_F1); add(O_JAL, 0, 0, 4'd1, C_DEC);
        add(O_JAL, 0, 0, 4'd10, C_JAL); add(O_JAL, 0, 0, 4'd8, C_AWB);
        // fetch stalled four cycles, ready on the fifth: no error
        add(O_R, 0, 0, 4'd0, C_F0); add(O_R, 0, 0, 4'd0, C_F0);
        add(O_R, 0, 0, 4'd0, C_F0); add(O_R, 0, 0, 4'd0, C_F0);
        add(O_R, 0, 1, 4'd0, C_F1); add(O_R, 0, 1, 4'd1, C_DEC);
        add(O_R, 0, 1, 4'd6, C_EXR); add(O_R, 0, 1, 4'd8, C_AWB);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // illegal opcode: ERR is sticky until reset
        stepv(O_BAD, 0, 1, 4'd0, C_F1);
        stepv(O_BAD, 0, 1, 4'd1, C_DEC);
        for (int i = 0; i < 20; i++) stepv(O_R, i[0], i[1], 4'd11, C_ERR);
        pulse_reset("illegal_clear");

        // fetch timeout: five stalled cycles then ERR
        for (int i = 0; i < 5; i++) stepv(O_R, 0, 0, 4'd0, C_F0);
        stepv(O_R, 0, 1, 4'd11, C_ERR);
        stepv(O_R, 0, 1, 4'd11, C_ERR);
        pulse_reset("timeout_clear");

        // async reset in the middle of a stalled store
        stepv(O_SW, 0, 1, 4'd0, C_F1);
        stepv(O_SW, 0, 1, 4'd1, C_DEC);
        stepv(O_SW, 0, 1, 4'd2, C_MA);
        stepv(O_SW, 0, 0, 4'd5, C_MW);
        stepv(O_SW, 0, 0, 4'd5, C_MW);
        pulse_reset("memwr_abort");
        stepv(O_SW, 0, 0, 4'd0, C_F0);
        stepv(O_R, 0, 1, 4'd0, C_F1);
        stepv(O_R, 0, 1, 4'd1, C_DEC);
        stepv(O_R, 0, 1, 4'd6, C_EXR);
        stepv(O_R, 0, 1, 4'd8, C_AWB);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
